// File: rtl/pkt_buf_cell_alloc.sv
// pkt_buf_cell_alloc
// Free-list manager and round-robin allocation arbiter for the shared
// packet-buffer cell pool. After reset the free list is filled with cell IDs
// 0..NUM_CELLS-1, one per cycle. From then on it grants at most one free cell
// per cycle to the ingress requesters and accepts at most one returned cell per
// cycle from the egress side.
//
// Ports:
//   clk, rst_n     core clock, synchronous active-low reset
//   alloc_req      per-requester level request
//   alloc_gnt      one-hot grant, 1-cycle pulse (registered)
//   alloc_cell_id  granted cell ID, valid with any alloc_gnt bit
//   free_valid     cell-return strobe
//   free_cell_id   cell being returned
//   free_ready     free port accepting (RUN only)
//   init_done      free list initialised, pool usable
//   free_count     cells currently free, 0..NUM_CELLS
//   low_wm         free_count < LOW_WM
//   free_ovf_err   1-cycle pulse when a return is dropped on a full list
module pkt_buf_cell_alloc #(
    parameter int NUM_REQ   = 32,
    parameter int NUM_CELLS = 1024,
    parameter int CELL_ID_W = $clog2(NUM_CELLS),
    parameter int LOW_WM    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   alloc_req,
    output logic [NUM_REQ-1:0]   alloc_gnt,
    output logic [CELL_ID_W-1:0] alloc_cell_id,
    input  logic                 free_valid,
    input  logic [CELL_ID_W-1:0] free_cell_id,
    output logic                 free_ready,
    output logic                 init_done,
    output logic [CELL_ID_W:0]   free_count,
    output logic                 low_wm,
    output logic                 free_ovf_err
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CELL_ID_W:0]   FULL     = (CELL_ID_W+1)'(NUM_CELLS);
    localparam logic [CELL_ID_W:0]   WM       = (CELL_ID_W+1)'(LOW_WM);
    localparam logic [CELL_ID_W:0]   CNT_ONE  = (CELL_ID_W+1)'(1);
    localparam logic [CELL_ID_W-1:0] PTR_ONE  = CELL_ID_W'(1);
    localparam logic [CELL_ID_W-1:0] LAST_ID  = CELL_ID_W'(NUM_CELLS-1);
    localparam logic [RR_W-1:0]      LAST_REQ = RR_W'(NUM_REQ-1);
    localparam logic [RR_W-1:0]      RR_ONE   = RR_W'(1);
    localparam logic [RR_W:0]        NREQ_C   = (RR_W+1)'(NUM_REQ);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t state, state_nxt;

    logic [CELL_ID_W-1:0] fifo [NUM_CELLS];
    logic [CELL_ID_W-1:0] rd_ptr, wr_ptr;
    logic [RR_W-1:0]      rr_ptr, win_idx, cand;
    logic [RR_W:0]        sum;
    logic                 win_any;
    logic                 do_init_wr, do_alloc, do_free, do_ovf;
    logic                 list_full, list_empty;
    logic [CELL_ID_W:0]   count_nxt;

    assign list_full  = (free_count == FULL);
    assign list_empty = (free_count == '0);

    // Round-robin search: walk from rr_ptr upward (mod NUM_REQ). The loop runs
    // high-to-low so the requester closest to rr_ptr is the last to assign.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (RR_W+1)'(i);
            if (sum >= NREQ_C) sum = sum - NREQ_C;
            cand = sum[RR_W-1:0];
            if (alloc_req[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    // INIT reuses wr_ptr as the fill counter: entry k is written with ID k, and
    // the natural wrap of wr_ptr leaves it at 0 on entry to RUN.
    always_comb begin
        state_nxt  = state;
        do_init_wr = 1'b0;
        do_alloc   = 1'b0;
        do_free    = 1'b0;
        do_ovf     = 1'b0;
        case (state)
            ST_INIT: begin
                do_init_wr = 1'b1;
                if (wr_ptr == LAST_ID) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // No bypass: a cell freed this cycle is only grantable next cycle.
                do_alloc = win_any && !list_empty;
                // Full check uses the current count, ignoring a same-cycle grant.
                do_free  = free_valid && !list_full;
                do_ovf   = free_valid && list_full;
            end
        endcase
    end

    always_comb begin
        count_nxt = free_count;
        if (do_init_wr || (do_free && !do_alloc))
            count_nxt = free_count + CNT_ONE;
        else if (do_alloc && !do_free)
            count_nxt = free_count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            rr_ptr        <= '0;
            free_count    <= '0;
            alloc_gnt     <= '0;
            alloc_cell_id <= '0;
            free_ready    <= 1'b0;
            init_done     <= 1'b0;
            low_wm        <= 1'b1;
            free_ovf_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            free_count   <= count_nxt;
            low_wm       <= (count_nxt < WM);
            free_ovf_err <= do_ovf;
            init_done    <= (state_nxt == ST_RUN);
            free_ready   <= (state_nxt == ST_RUN);
            alloc_gnt    <= '0;
            if (do_init_wr || do_free) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_alloc) begin
                alloc_gnt[win_idx] <= 1'b1;
                alloc_cell_id      <= fifo[rd_ptr];
                rd_ptr             <= rd_ptr + PTR_ONE;
                rr_ptr             <= (win_idx == LAST_REQ) ? '0 : win_idx + RR_ONE;
            end
        end
    end

    // Free-list storage; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst_n && (do_init_wr || do_free))
            fifo[wr_ptr] <= do_init_wr ? wr_ptr : free_cell_id;
    end

endmodule
